// File: rtl/split_assign_driver_if.sv
// Bundle of the solver-side word stream, checker hookup and result channel.
// Every channel uses valid/ready: a transfer happens on a rising edge where both are high.
interface split_assign_driver_if #(
   parameter int VAR_BITS = 368,
   parameter int IN_W     = 32,
   parameter int IDX_W    = 16
);
   logic                s_valid;
   logic                s_ready;
   logic [IN_W-1:0]     s_data;
   logic                s_last;
   logic [VAR_BITS-1:0] var_bus;
   logic                chk_valid;
   logic                chk_x;
   logic                r_valid;
   logic                r_ready;
   logic                r_sat;
   logic                r_err;
   logic [IDX_W-1:0]    r_index;

   modport master (
      output s_valid, s_data, s_last, chk_x, r_ready,
      input  s_ready, var_bus, chk_valid, r_valid, r_sat, r_err, r_index
   );

   modport slave (
      input  s_valid, s_data, s_last, chk_x, r_ready,
      output s_ready, var_bus, chk_valid, r_valid, r_sat, r_err, r_index
   );
endinterface

// File: rtl/split_assign_driver.sv
// Assembles packed candidate assignments from a word stream, presents them to a
// constraint checker for CHECK_LAT+1 cycles and returns a tagged sat/err verdict.
module split_assign_driver #(
   parameter int VAR_BITS  = 368,
   parameter int IN_W      = 32,
   parameter int CHECK_LAT = 0,
   parameter int IDX_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   split_assign_driver_if.slave   bus,
   output logic                   busy,
   output logic [1:0]             dbg_state
);
   localparam int NUM_WORDS = (VAR_BITS + IN_W - 1) / IN_W;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int WAIT_W    = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;
   localparam int STAGE_W   = NUM_WORDS * IN_W;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      HOLD   = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     count;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [STAGE_W-1:0]   stage, stage_nxt;
   logic [VAR_BITS-1:0]  var_q;
   logic                 sat_q, err_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 xfer, last_slot, close, hold_done, r_fire;

   assign xfer      = bus.s_valid && bus.s_ready;
   assign last_slot = (count == CNT_W'(NUM_WORDS - 1));
   assign close     = xfer && (bus.s_last || last_slot);
   assign hold_done = (wait_cnt == WAIT_W'(CHECK_LAT));
   assign r_fire    = bus.r_valid && bus.r_ready;

   // Staging image including the word arriving this cycle, so the close
   // transfer can copy a complete candidate straight onto var_bus.
   always_comb begin
      stage_nxt = stage;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (count == CNT_W'(k)) stage_nxt[k*IN_W +: IN_W] = bus.s_data;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.s_ready   = 1'b0;
      bus.chk_valid = 1'b0;
      bus.r_valid   = 1'b0;
      case (state)
         LOAD: begin
            bus.s_ready = !rst;
            if (close) state_nxt = HOLD;
         end
         HOLD: begin
            bus.chk_valid = 1'b1;
            if (hold_done) state_nxt = REPORT;
         end
         REPORT: begin
            bus.r_valid = 1'b1;
            if (bus.r_ready) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= LOAD;
         count    <= '0;
         wait_cnt <= '0;
         stage    <= '0;
         var_q    <= '0;
         sat_q    <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            if (close) begin
               // Clearing the staging buffer keeps unreceived words of the next candidate zero.
               count <= '0;
               stage <= '0;
               var_q <= stage_nxt[VAR_BITS-1:0];
               err_q <= bus.s_last ^ last_slot;
               sat_q <= 1'b0;
            end else begin
               count <= count + CNT_W'(1);
               stage <= stage_nxt;
            end
         end
         if (state == HOLD) begin
            if (hold_done) begin
               wait_cnt <= '0;
               sat_q    <= bus.chk_x & ~err_q;
            end else begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
            end
         end
         if (r_fire) idx_q <= idx_q + IDX_W'(1);
      end
   end

   assign bus.var_bus = var_q;
   assign bus.r_sat   = sat_q;
   assign bus.r_err   = err_q;
   assign bus.r_index = idx_q;
   assign busy        = (state != LOAD) || (count != '0);
   assign dbg_state   = state;
endmodule

// File: tb/tb_split_assign_driver.sv
// Directed bench: dut_a (CHECK_LAT=0, 16-bit index) and dut_b (CHECK_LAT=3, 4-bit index).
module tb_split_assign_driver;
   localparam int VB = 368;
   localparam int IW = 32;
   localparam int NW = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy_a, busy_b;
   logic [1:0] st_a, st_b;

   split_assign_driver_if #(.VAR_BITS(VB), .IN_W(IW), .IDX_W(16)) ia ();
   split_assign_driver_if #(.VAR_BITS(VB), .IN_W(IW), .IDX_W(4))  ib ();

   split_assign_driver #(.VAR_BITS(VB), .IN_W(IW), .CHECK_LAT(0), .IDX_W(16)) dut_a (
      .clk(clk), .rst(rst), .bus(ia.slave), .busy(busy_a), .dbg_state(st_a)
   );
   split_assign_driver #(.VAR_BITS(VB), .IN_W(IW), .CHECK_LAT(3), .IDX_W(4)) dut_b (
      .clk(clk), .rst(rst), .bus(ib.slave), .busy(busy_b), .dbg_state(st_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [17:0] exp_q[$];   // {r_index, r_err, r_sat}

   typedef struct {
      logic [31:0] base;
      int          nwords;
      logic        last;
      logic        chk;
      logic        exp_err;
      logic        exp_sat;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [VB-1:0] act, input logic [VB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [VB-1:0] model_var(input logic [31:0] base, input int n);
      logic [NW*IW-1:0] s;
      s = '0;
      for (int k = 0; k < n; k++) s[k*IW +: IW] = base + 32'(k);
      return s[VB-1:0];
   endfunction

   // driver tasks: called and returning at a falling edge
   task automatic a_send(input logic [31:0] d, input logic l, input int gap);
      logic rdy;
      int   guard;
      guard = 0;
      repeat (gap) @(negedge clk);
      ia.s_valid = 1'b1; ia.s_data = d; ia.s_last = l;
      forever begin
         rdy = ia.s_ready;
         @(negedge clk);
         if (rdy) break;
         guard++;
         if (guard > 50) begin check("a_send_timeout", 1, 0); break; end
      end
      ia.s_valid = 1'b0; ia.s_last = 1'b0;
   endtask

   task automatic b_send(input logic [31:0] d, input logic l);
      logic rdy;
      int   guard;
      guard = 0;
      ib.s_valid = 1'b1; ib.s_data = d; ib.s_last = l;
      forever begin
         rdy = ib.s_ready;
         @(negedge clk);
         if (rdy) break;
         guard++;
         if (guard > 50) begin check("b_send_timeout", 1, 0); break; end
      end
      ib.s_valid = 1'b0; ib.s_last = 1'b0;
   endtask

   task automatic a_get(output logic [17:0] res, output logic [VB-1:0] vb);
      int guard;
      guard = 0;
      while (!ia.r_valid && guard < 50) begin @(negedge clk); guard++; end
      if (!ia.r_valid) check("a_get_timeout", 0, 1);
      res = {ia.r_index, ia.r_err, ia.r_sat};
      vb  = ia.var_bus;
      ia.r_ready = 1'b1;
      @(negedge clk);
      ia.r_ready = 1'b0;
   endtask

   task automatic b_get(output logic [17:0] res);
      int guard;
      guard = 0;
      while (!ib.r_valid && guard < 50) begin @(negedge clk); guard++; end
      if (!ib.r_valid) check("b_get_timeout", 0, 1);
      res = {12'd0, ib.r_index, ib.r_err, ib.r_sat};
      ib.r_ready = 1'b1;
      @(negedge clk);
      ib.r_ready = 1'b0;
   endtask

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [17:0]   res, expv;
      logic [VB-1:0] vb, vb5, snap_vb;
      logic [17:0]   snap_res;
      int            n, n_chk, unstable;

      vecs[0] = '{32'h0000_0001, 12, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'hA5A5_0000,  5, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{32'h0000_0010, 12, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{32'hFFFF_FFF0, 12, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{32'h0000_0100,  1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{32'hDEAD_0000, 12, 1'b1, 1'b1, 1'b0, 1'b1};

      ia.s_valid = 0; ia.s_data = '0; ia.s_last = 0; ia.chk_x = 0; ia.r_ready = 0;
      ib.s_valid = 0; ib.s_data = '0; ib.s_last = 0; ib.chk_x = 0; ib.r_ready = 0;

      @(negedge clk);
      check("rst_s_ready", ia.s_ready, 0);
      check("rst_var_bus", ia.var_bus, 0);
      check("rst_r_valid", ia.r_valid, 0);
      check("rst_r_index", ia.r_index, 0);
      check("rst_busy", busy_a, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", ia.s_ready, 1);

      // dut_b: CHECK_LAT=3 hold window and latency
      ib.chk_x = 1'b0;
      exp_q.push_back({16'd0, 1'b0, 1'b0});
      for (int k = 0; k < NW; k++) b_send(32'h20 + 32'(k), k == NW - 1);
      n = 0; n_chk = 0;
      while (!ib.r_valid && n < 20) begin
         if (ib.chk_valid) n_chk++;
         @(negedge clk);
         n++;
      end
      check("b_chk_valid_cycles", n_chk, 4);
      check("b_r_valid_latency", n, 4);
      b_get(res);
      expv = exp_q.pop_front();
      check("b_lat3_result", res, expv);

      // chk_x is only meaningful on the last HOLD cycle
      exp_q.push_back({16'd1, 1'b0, 1'b1});
      for (int k = 0; k < NW; k++) b_send(32'h40 + 32'(k), k == NW - 1);
      repeat (3) @(negedge clk);
      ib.chk_x = 1'b1;
      @(negedge clk);
      ib.chk_x = 1'b0;
      check("b_sample_r_valid", ib.r_valid, 1);
      b_get(res);
      expv = exp_q.pop_front();
      check("b_sample_last_cycle", res, expv);

      // index wrap with short errored candidates
      ib.chk_x = 1'b1;
      for (int i = 2; i <= 16; i++) begin
         exp_q.push_back({12'd0, 4'(i), 1'b1, 1'b0});
         b_send(32'(i), 1'b1);
         b_get(res);
         expv = exp_q.pop_front();
         check($sformatf("b_wrap_%0d", i), res, expv);
      end

      // dut_a: table-driven candidates with random s_valid gaps
      for (int v = 0; v < 6; v++) begin
         ia.chk_x = vecs[v].chk;
         exp_q.push_back({16'(v), vecs[v].exp_err, vecs[v].exp_sat});
         for (int k = 0; k < vecs[v].nwords; k++)
            a_send(vecs[v].base + 32'(k), (k == vecs[v].nwords - 1) && vecs[v].last,
                   $urandom_range(0, 2));
         check($sformatf("v%0d_chk_valid_t1", v), ia.chk_valid, 1);
         check($sformatf("v%0d_r_valid_t1", v), ia.r_valid, 0);
         check($sformatf("v%0d_busy_hold", v), busy_a, 1);
         @(negedge clk);
         check($sformatf("v%0d_r_valid_t2", v), ia.r_valid, 1);
         check($sformatf("v%0d_chk_valid_t2", v), ia.chk_valid, 0);
         a_get(res, vb);
         expv = exp_q.pop_front();
         check($sformatf("v%0d_result", v), res, expv);
         check($sformatf("v%0d_var_bus", v), vb, model_var(vecs[v].base, vecs[v].nwords));
         check($sformatf("v%0d_busy_idle", v), busy_a, 0);
         if (v == 0) begin
            check("t1_low_word", vb[31:0], 32'h1);
            check("t1_top_bits", vb[367:352], 16'h000C);
         end
         if (v == 1) check("t3_zero_tail", vb[367:160], 0);
         if (v == 5) vb5 = vb;
      end

      // backpressure in REPORT, same data as vector 5 with different gaps
      ia.chk_x = 1'b1;
      for (int k = 0; k < NW; k++)
         a_send(32'hDEAD_0000 + 32'(k), k == NW - 1, (k % 3 == 0) ? 3 : 0);
      @(negedge clk);
      snap_vb  = ia.var_bus;
      snap_res = {ia.r_index, ia.r_err, ia.r_sat};
      check("bp_var_bus_gaps", snap_vb, vb5);
      ia.s_valid = 1'b1; ia.s_data = 32'hBAD0_BAD0; ia.s_last = 1'b1;
      unstable = 0;
      for (int c = 0; c < 20; c++) begin
         if (ia.s_ready || !ia.r_valid || ia.var_bus !== snap_vb ||
             {ia.r_index, ia.r_err, ia.r_sat} !== snap_res) unstable++;
         @(negedge clk);
      end
      check("bp_stable_cycles", unstable, 0);
      ia.s_valid = 1'b0; ia.s_last = 1'b0;
      a_get(res, vb);
      check("bp_result", res, {16'd6, 1'b0, 1'b1});
      repeat (2) @(negedge clk);
      check("bp_no_extra_result", ia.r_valid, 0);
      check("bp_no_extra_word", busy_a, 0);

      // reset while in REPORT
      for (int k = 0; k < NW; k++) a_send(32'h7000 + 32'(k), k == NW - 1, 0);
      @(negedge clk);
      check("rst_report_pre", ia.r_valid, 1);
      rst = 1'b1;
      #1;
      check("rst_report_r_valid", ia.r_valid, 0);
      check("rst_report_r_index", ia.r_index, 0);
      check("rst_report_var_bus", ia.var_bus, 0);
      check("rst_report_s_ready", ia.s_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // one clean candidate, then reset while in HOLD
      for (int k = 0; k < NW; k++) a_send(32'h8000 + 32'(k), k == NW - 1, 0);
      a_get(res, vb);
      check("rst_mid_result", res, {16'd0, 1'b0, 1'b1});
      for (int k = 0; k < NW; k++) a_send(32'h9000 + 32'(k), k == NW - 1, 0);
      check("rst_hold_pre", ia.chk_valid, 1);
      rst = 1'b1;
      #1;
      check("rst_hold_chk_valid", ia.chk_valid, 0);
      check("rst_hold_r_index", ia.r_index, 0);
      check("rst_hold_var_bus", ia.var_bus, 0);
      check("rst_hold_busy", busy_a, 0);
      check("rst_hold_r_err_sat", {ia.r_err, ia.r_sat}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NW; k++) a_send(32'hA000 + 32'(k), k == NW - 1, 0);
      a_get(res, vb);
      check("rst_fresh_result", res, {16'd0, 1'b0, 1'b1});
      check("rst_fresh_var_bus", vb, model_var(32'hA000, NW));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
